// File: rtl/util_mw_adc_bridge_pkg.sv
// Shared types and constants for the ADC-side bridge controller.
package util_mw_adc_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned DROP_CNT_W = 16;
  localparam int unsigned MAX_CHAN   = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/util_mw_adc_bridge_fifo.sv
// Show-ahead FIFO: head entry is always presented on dout while not empty.
module util_mw_adc_bridge_fifo
  import util_mw_adc_bridge_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[PTR_W'(i)] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/util_mw_adc_bridge_ctl.sv
// ADC -> user IP -> DMA bridge: sample capture, result packing, word FIFO
// and a run/drain sequencer that keeps DMA writes inside transfer windows.
module util_mw_adc_bridge_ctl
  import util_mw_adc_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_CHAN   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           adc_valid_0, adc_valid_1, adc_valid_2, adc_valid_3,
  input  logic                           adc_valid_4, adc_valid_5, adc_valid_6, adc_valid_7,
  input  logic                           adc_enable_0, adc_enable_1, adc_enable_2, adc_enable_3,
  input  logic                           adc_enable_4, adc_enable_5, adc_enable_6, adc_enable_7,
  input  logic [DATA_WIDTH-1:0]          adc_data_0, adc_data_1, adc_data_2, adc_data_3,
  input  logic [DATA_WIDTH-1:0]          adc_data_4, adc_data_5, adc_data_6, adc_data_7,
  output logic                           bridge_enable_out,
  output logic                           bridge_valid_out,
  output logic [DATA_WIDTH-1:0]          bridge_out_0, bridge_out_1, bridge_out_2, bridge_out_3,
  output logic [DATA_WIDTH-1:0]          bridge_out_4, bridge_out_5, bridge_out_6, bridge_out_7,
  input  logic                           bridge_valid_in,
  input  logic [DATA_WIDTH-1:0]          bridge_in_0, bridge_in_1, bridge_in_2, bridge_in_3,
  input  logic [DATA_WIDTH-1:0]          bridge_in_4, bridge_in_5, bridge_in_6, bridge_in_7,
  input  logic                           dmac_xfer_req,
  output logic                           dmac_valid,
  input  logic                           dmac_ready,
  output logic [DATA_WIDTH*NUM_CHAN-1:0] dmac_data,
  output logic                           adc_dovf,
  output logic [DROP_CNT_W-1:0]          drop_count
);

  localparam int unsigned DW     = DATA_WIDTH;
  localparam int unsigned PACK_W = DATA_WIDTH * NUM_CHAN;
  localparam int unsigned BUS_W  = DATA_WIDTH * MAX_CHAN;
  // Keeps only the active channels so unused bridge outputs stay at zero.
  localparam logic [BUS_W-1:0] CAP_MASK = {BUS_W{1'b1}} >> (BUS_W - PACK_W);

  logic [MAX_CHAN-1:0]   adc_valid_all;
  logic [MAX_CHAN-1:0]   adc_enable_all;
  logic [BUS_W-1:0]      adc_data_all;
  logic [BUS_W-1:0]      bridge_in_all;

  state_e                state_q, state_d;
  logic                  enable_q;
  logic                  bvalid_q;
  logic                  dovf_q;
  logic [BUS_W-1:0]      cap_q;
  logic [DROP_CNT_W-1:0] drop_q;

  logic                  capture;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  ovf_event;
  logic [PACK_W-1:0]     fifo_dout;
  logic                  unused_inputs;

  assign adc_valid_all  = {adc_valid_7, adc_valid_6, adc_valid_5, adc_valid_4,
                           adc_valid_3, adc_valid_2, adc_valid_1, adc_valid_0};
  assign adc_enable_all = {adc_enable_7, adc_enable_6, adc_enable_5, adc_enable_4,
                           adc_enable_3, adc_enable_2, adc_enable_1, adc_enable_0};
  assign adc_data_all   = {adc_data_7, adc_data_6, adc_data_5, adc_data_4,
                           adc_data_3, adc_data_2, adc_data_1, adc_data_0};
  assign bridge_in_all  = {bridge_in_7, bridge_in_6, bridge_in_5, bridge_in_4,
                           bridge_in_3, bridge_in_2, bridge_in_1, bridge_in_0};
  assign unused_inputs  = ^{adc_data_all, bridge_in_all};

  assign capture   = (state_q == ST_RUN) && (|adc_valid_all);
  assign fifo_push = (state_q != ST_IDLE) && bridge_valid_in;
  assign fifo_pop  = !fifo_empty && dmac_ready;
  assign ovf_event = fifo_push && fifo_full && !fifo_pop;

  // Sequencer next state; DRAIN always returns through IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (dmac_xfer_req && enable_q) state_d = ST_RUN;
      ST_RUN:   if (!dmac_xfer_req || !enable_q) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && !bridge_valid_in) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      enable_q <= 1'b0;
      bvalid_q <= 1'b0;
      dovf_q   <= 1'b0;
      cap_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      enable_q <= |adc_enable_all;
      bvalid_q <= capture;
      dovf_q   <= ovf_event;
      if (capture) cap_q <= adc_data_all & CAP_MASK;
      if (ovf_event && (drop_q != '1)) drop_q <= drop_q + DROP_CNT_W'(1);
    end
  end

  util_mw_adc_bridge_fifo #(
    .WIDTH (PACK_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bridge_in_all[PACK_W-1:0]),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bridge_enable_out = enable_q;
  assign bridge_valid_out  = bvalid_q;
  assign bridge_out_0      = cap_q[0*DW +: DW];
  assign bridge_out_1      = cap_q[1*DW +: DW];
  assign bridge_out_2      = cap_q[2*DW +: DW];
  assign bridge_out_3      = cap_q[3*DW +: DW];
  assign bridge_out_4      = cap_q[4*DW +: DW];
  assign bridge_out_5      = cap_q[5*DW +: DW];
  assign bridge_out_6      = cap_q[6*DW +: DW];
  assign bridge_out_7      = cap_q[7*DW +: DW];
  assign dmac_valid        = !fifo_empty;
  assign dmac_data         = fifo_dout;
  assign adc_dovf          = dovf_q;
  assign drop_count        = drop_q;

endmodule

// File: doc/util_mw_adc_bridge_ctl.md
Name: util_mw_adc_bridge_ctl

Overview:
Receive-side counterpart of the DAC bridge: ADC channels -> bridge_out -> [User IP] -> bridge_in -> DMA write port.
- Captures per-channel ADC samples, presents them to the user IP and packs the user IP's NUM_CHAN results into one DMA word.
- Buffers packed words in a small FIFO with valid/ready backpressure and overflow reporting.
- A run/drain state machine keeps writes aligned to DMA transfer requests.

Parameters:
DATA_WIDTH, 16, bits per channel sample
NUM_CHAN, 4, active channels (1..8); channels NUM_CHAN..7 are unused
FIFO_DEPTH, 4, packed-word FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous assert, active-low (0 = reset)
adc_valid_0..7  in  1  per-channel ADC sample valid
adc_enable_0..7  in  1  per-channel enable from ADC core
adc_data_0..7  in  DATA_WIDTH  per-channel ADC sample
bridge_enable_out  out  1  registered OR of adc_enable_0..7
bridge_valid_out  out  1  sample strobe to user IP
bridge_out_0..7  out  DATA_WIDTH  captured samples to user IP
bridge_valid_in  in  1  user IP result strobe
bridge_in_0..7  in  DATA_WIDTH  user IP results
dmac_xfer_req  in  1  DMA transfer active
dmac_valid  out  1  FIFO head valid
dmac_ready  in  1  DMA accepts word
dmac_data  out  DATA_WIDTH*NUM_CHAN  packed word, channel 0 in LSBs
adc_dovf  out  1  one-cycle overflow pulse
drop_count  out  16  saturating count of dropped words

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; FIFO empty; drop_count 0.
- bridge_enable_out: OR of enables, 1-cycle register latency.
- State machine (states IDLE, RUN, DRAIN):
  - IDLE->RUN when dmac_xfer_req=1 and bridge_enable_out=1.
  - RUN->DRAIN when dmac_xfer_req=0 or bridge_enable_out=0.
  - DRAIN->IDLE when FIFO empty and bridge_valid_in=0 in the same cycle.
  - DRAIN->RUN never directly; the block passes through IDLE first.
- Capture: in RUN only, when any adc_valid_n=1:
  - bridge_out_n <= adc_data_n for n<NUM_CHAN; bridge_out_n held 0 for n>=NUM_CHAN.
  - bridge_valid_out=1 for exactly one cycle; latency 1.
  - Outside RUN, bridge_valid_out=0 and bridge_out_n hold their last value.
- Pack/push: in RUN or DRAIN, bridge_valid_in=1 pushes {bridge_in_(NUM_CHAN-1),...,bridge_in_0} into the FIFO. In IDLE, bridge_valid_in is ignored (no push, no overflow).
- FIFO is show-ahead:
  - dmac_valid = !empty; dmac_data = head entry.
  - A pop occurs when dmac_valid & dmac_ready.
  - A pushed word is visible on dmac_data the cycle after the push.
- Full with push and no pop: the word is dropped (FIFO contents unchanged); adc_dovf=1 the next cycle for one cycle; drop_count+1, saturating at 0xFFFF.
- Full with push and pop in the same cycle: both happen, no drop, occupancy unchanged.
- Empty with push and pop: pop not possible (dmac_valid=0); push only.
- Pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
- Entering IDLE: FIFO is already empty by construction. drop_count clears only on reset.
- dmac_data is unchanged while dmac_valid=1 and dmac_ready=0 (valid/ready rule: no retraction).

Decomposition:
- Package util_mw_adc_bridge_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DRAIN=2'd2;
  - DROP_CNT_W=16;
  - a clog2 function for pointer widths.
- Sub-module util_mw_adc_bridge_fifo: show-ahead FIFO with parameters WIDTH and DEPTH; ports push, pop, din, dout, empty, full.
- The top level contains the capture registers, state machine, packing and overflow logic.

Test Plan:
- Reset mid-RUN with 2 words queued: assert rst=0 -> all outputs 0 asynchronously, FIFO empty, state IDLE; after release, no dmac_valid until xfer_req and enable are both 1.
- Capture: NUM_CHAN=4, enable_0=1, xfer_req=1, adc_valid_0 pulse with data 0x1111..0x4444 -> bridge_valid_out one-cycle pulse 1 cycle later; bridge_out_0..3=0x1111..0x4444; bridge_out_4..7=0.
- Packing: bridge_in_0..3=0xA0,0xB1,0xC2,0xD3 with bridge_valid_in, dmac_ready=1 -> next cycle dmac_valid=1, dmac_data=0x00D300C200B100A0.
- Overflow: dmac_ready=0, 5 pushes with FIFO_DEPTH=4 -> 5th push dropped, one adc_dovf pulse, drop_count=1; then dmac_ready=1 -> exactly 4 words out in order.
- Full with simultaneous push and pop: FIFO full, dmac_ready=1 and bridge_valid_in=1 in one cycle -> no adc_dovf, occupancy stays 4, new word appears last.
- Drain: 3 words queued, dmac_xfer_req falls -> no new bridge_valid_out; late bridge_valid_in accepted; all 4 words delivered; state returns to IDLE after the FIFO is empty.
